// File: rtl/td4_pkg.sv
// Shared types for the TD4 serial program loader.
// Holds the loader FSM states and the byte-to-word split.
package td4_pkg;

   localparam int ADDR_W   = 4;
   localparam int NIBBLE_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WRITE
   } state_t;

   function automatic logic [NIBBLE_W-1:0] byte_opcode(
      input logic [7:0] b
   );
      return b[7:4];
   endfunction

   function automatic logic [NIBBLE_W-1:0] byte_imm(
      input logic [7:0] b
   );
      return b[3:0];
   endfunction

endpackage

// File: rtl/td4_prog_loader_if.sv
// Program-memory write bus driven by the loader.
// The master drives one-cycle strobes with address and data.
interface td4_prog_loader_if;
   import td4_pkg::*;

   logic [ADDR_W-1:0]   mem_addr;
   logic [NIBBLE_W-1:0] mem_opcode;
   logic [NIBBLE_W-1:0] mem_imm;
   logic                mem_we;

   modport master (
      output mem_addr,
      output mem_opcode,
      output mem_imm,
      output mem_we
   );

   modport slave (
      input mem_addr,
      input mem_opcode,
      input mem_imm,
      input mem_we
   );

endinterface

// File: rtl/td4_uart_rx.sv
// UART 8N1 receiver: synchroniser, baud counter and frame parser.
// Emits a one-cycle byte_valid or frame_err pulse at the stop sample.
module td4_uart_rx
   import td4_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   input  logic       abort_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic          rx_s1_q;
   logic          rx_s2_q;
   logic          rx_prev_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      sh_d         = sh_q;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_d = '0;
                  idx_d = '0;
                  // Line back high at mid-start: treat as a glitch
                  state_d = rx_s2_q ? IDLE : DATA;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == FULL_M1) begin
                  sh_d  = {rx_s2_q, sh_q[7:1]};
                  cnt_d = '0;
                  idx_d = idx_q + 1'b1;
                  if (idx_q == 3'd7) state_d = STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == FULL_M1) begin
                  byte_valid_o = rx_s2_q;
                  frame_err_o  = !rx_s2_q;
                  state_d      = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign byte_o = sh_q;

endmodule

// File: rtl/td4_prog_loader.sv
// Serial loader for the 16-word TD4 program memory.
// Stalls the CPU while a session writes one word per received byte.
module td4_prog_loader
   import td4_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int MEM_DEPTH    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx,
   input  logic               load_req,
   td4_prog_loader_if.master  mem,
   output logic               cpu_hold,
   output logic               busy,
   output logic               loaded,
   output logic               frame_err
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

   logic                lr_s1_q, lr_s2_q, lr_s3_q;
   logic                lr_edge;
   logic [7:0]          rx_byte;
   logic                rx_valid;
   logic                rx_ferr;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [NIBBLE_W-1:0] op_q, op_d;
   logic [NIBBLE_W-1:0] imm_q, imm_d;
   logic                busy_q, busy_d;
   logic                loaded_q, loaded_d;
   logic                ferr_q, ferr_d;
   logic                we;

   assign lr_edge = lr_s2_q && !lr_s3_q;

   td4_uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_i         (rx),
      .abort_i      (lr_edge),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_ferr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_s1_q  <= 1'b0;
         lr_s2_q  <= 1'b0;
         lr_s3_q  <= 1'b0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         op_q     <= '0;
         imm_q    <= '0;
         busy_q   <= 1'b0;
         loaded_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         lr_s1_q  <= load_req;
         lr_s2_q  <= lr_s1_q;
         lr_s3_q  <= lr_s2_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         op_q     <= op_d;
         imm_q    <= imm_d;
         busy_q   <= busy_d;
         loaded_q <= loaded_d;
         ferr_q   <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      op_d     = op_q;
      imm_d    = imm_q;
      busy_d   = busy_q;
      loaded_d = loaded_q;
      ferr_d   = ferr_q;
      we       = 1'b0;
      if (lr_edge) begin
         // A new session request overrides any pending write
         state_d  = IDLE;
         cnt_d    = '0;
         busy_d   = 1'b1;
         loaded_d = 1'b0;
         ferr_d   = 1'b0;
      end else begin
         if (rx_ferr) ferr_d = 1'b1;
         unique case (state_q)
            IDLE: begin
               if (rx_valid && busy_q) begin
                  state_d = WRITE;
                  addr_d  = cnt_q;
                  op_d    = byte_opcode(rx_byte);
                  imm_d   = byte_imm(rx_byte);
               end
            end
            WRITE: begin
               we      = 1'b1;
               state_d = IDLE;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d    = '0;
                  busy_d   = 1'b0;
                  loaded_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign mem.mem_addr   = addr_q;
   assign mem.mem_opcode = op_q;
   assign mem.mem_imm    = imm_q;
   assign mem.mem_we     = we;
   assign cpu_hold       = busy_q;
   assign busy           = busy_q;
   assign loaded         = loaded_q;
   assign frame_err      = ferr_q;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for the TD4 serial program loader.
// Logs every write strobe and checks it against hand-computed words.
module tb_td4_prog_loader;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic rx;
   logic load_req;
   logic cpu_hold, busy, loaded, frame_err;

   td4_prog_loader_if mem_if ();

   td4_prog_loader #(
      .CLKS_PER_BIT (CPB),
      .MEM_DEPTH    (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .load_req  (load_req),
      .mem       (mem_if.master),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .loaded    (loaded),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int nw = 0;
   logic [11:0] wlog [0:63];

   always @(negedge clk) begin
      if (mem_if.mem_we === 1'b1) begin
         if (nw < 64)
            wlog[nw] <= {mem_if.mem_addr, mem_if.mem_opcode,
                         mem_if.mem_imm};
         nw <= nw + 1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cyc(CPB);
      end
      rx = stop;
      cyc(CPB);
      rx = 1'b1;
      cyc(2 * CPB);
   endtask

   task automatic pulse_load;
      @(negedge clk);
      load_req = 1'b1;
      cyc(4);
      load_req = 1'b0;
      cyc(4);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      rx = 1'b1;
      load_req = 1'b0;
      cyc(3);
      tests++;
      if ({mem_if.mem_addr, mem_if.mem_opcode, mem_if.mem_imm,
           mem_if.mem_we, cpu_hold, busy, loaded, frame_err} !== 17'h0) begin
         fails++;
         $display("FAIL reset_outputs got %h want 0",
                  {mem_if.mem_addr, mem_if.mem_opcode, mem_if.mem_imm,
                   mem_if.mem_we, cpu_hold, busy, loaded, frame_err});
      end
      rst_n = 1'b1;
      cyc(200);
      tests++;
      if (nw !== 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_we writes=%0d busy=%b want 0/0", nw, busy);
      end
   endtask

   task automatic test_full_load;
      int base;
      pulse_load();
      tests++;
      if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
         fails++;
         $display("FAIL load_start busy=%b hold=%b want 1/1", busy, cpu_hold);
      end
      base = nw;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] b;
         b = 8'h30 + 8'(i);
         send_frame(b, 1'b1);
      end
      cyc(4);
      tests++;
      if (nw - base !== 16) begin
         fails++;
         $display("FAIL full_count got %0d want 16", nw - base);
      end
      for (int i = 0; i < 16; i++) begin
         logic [11:0] exp;
         exp = {4'(i), 4'h3, 4'(i)};
         tests++;
         if (wlog[base + i] !== exp) begin
            fails++;
            $display("FAIL full_word%0d got %h want %h", i,
                     wlog[base + i], exp);
         end
      end
      tests++;
      if ({loaded, busy, cpu_hold, frame_err} !== 4'b1000) begin
         fails++;
         $display("FAIL full_done l/b/h/f=%b want 1000",
                  {loaded, busy, cpu_hold, frame_err});
      end
   endtask

   task automatic test_not_busy;
      int base;
      base = nw;
      send_frame(8'h7E, 1'b1);
      cyc(4);
      tests++;
      if (nw - base !== 0) begin
         fails++;
         $display("FAIL notbusy_writes got %0d want 0", nw - base);
      end
      tests++;
      if (loaded !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL notbusy_flags loaded=%b busy=%b want 1/0",
                  loaded, busy);
      end
   endtask

   task automatic test_frame_err;
      int base;
      pulse_load();
      tests++;
      if (loaded !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL ferr_session loaded=%b busy=%b want 0/1",
                  loaded, busy);
      end
      base = nw;
      send_frame(8'hA5, 1'b0);
      tests++;
      if (frame_err !== 1'b1 || nw - base !== 0) begin
         fails++;
         $display("FAIL ferr_bad ferr=%b writes=%0d want 1/0",
                  frame_err, nw - base);
      end
      send_frame(8'hB2, 1'b1);
      cyc(4);
      tests++;
      if (nw - base !== 1 || wlog[base] !== 12'h0B2) begin
         fails++;
         $display("FAIL ferr_write n=%0d word=%h want 1/0b2",
                  nw - base, wlog[base]);
      end
      tests++;
      if (frame_err !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL ferr_sticky ferr=%b busy=%b want 1/1",
                  frame_err, busy);
      end
   endtask

   task automatic test_false_start;
      int base;
      pulse_load();
      tests++;
      if (frame_err !== 1'b0) begin
         fails++;
         $display("FAIL fs_clear ferr=%b want 0", frame_err);
      end
      base = nw;
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      cyc(6 * CPB);
      tests++;
      if (nw - base !== 0 || frame_err !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL fs_glitch writes=%0d ferr=%b busy=%b want 0/0/1",
                  nw - base, frame_err, busy);
      end
      send_frame(8'h5C, 1'b1);
      cyc(4);
      tests++;
      if (nw - base !== 1 || wlog[base] !== 12'h05C) begin
         fails++;
         $display("FAIL fs_next n=%0d word=%h want 1/05c",
                  nw - base, wlog[base]);
      end
   endtask

   task automatic test_restart;
      int base;
      pulse_load();
      base = nw;
      for (int i = 0; i < 5; i++) begin
         logic [7:0] b;
         b = 8'h40 + 8'(i);
         send_frame(b, 1'b1);
      end
      cyc(4);
      tests++;
      if (nw - base !== 5 || wlog[base + 4] !== 12'h444) begin
         fails++;
         $display("FAIL rs_five n=%0d last=%h want 5/444",
                  nw - base, wlog[base + 4]);
      end
      pulse_load();
      base = nw;
      send_frame(8'h12, 1'b1);
      cyc(4);
      tests++;
      if (nw - base !== 1 || wlog[base] !== 12'h012) begin
         fails++;
         $display("FAIL rs_write n=%0d word=%h want 1/012",
                  nw - base, wlog[base]);
      end
      tests++;
      if (loaded !== 1'b0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
         fails++;
         $display("FAIL rs_flags l/b/h=%b want 011",
                  {loaded, busy, cpu_hold});
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_not_busy();
      test_frame_err();
      test_false_start();
      test_restart();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Serial program loader sitting directly upstream of the TD4 program memory; receives a UART 8N1 byte stream and writes each byte as one {opcode, immediate} word into the 16-entry memory.
- Holds the CPU stalled while a load session runs and releases it once all 16 words are written.
- Replaces manual per-word pin writes with a single host download.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be even and >= 4.
- MEM_DEPTH, 16, words per load session; fixed to 16 for the 4-bit PC.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  UART receive line, idle high, asynchronous to clk
- load_req  input  1  level input; a rising edge starts or restarts a load session
- mem_addr  output  4  memory write address
- mem_opcode  output  4  write data, upper nibble of the received byte
- mem_imm  output  4  write data, lower nibble of the received byte
- mem_we  output  1  one-cycle write strobe, active high
- cpu_hold  output  1  high while loading; CPU must not advance PC
- busy  output  1  load session active
- loaded  output  1  sticky; set when all 16 words are written, cleared by load_req edge
- frame_err  output  1  sticky; set on a bad stop bit, cleared by load_req edge

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state:
  - mem_addr = 0, mem_opcode = 0, mem_imm = 0.
  - mem_we = 0, cpu_hold = 0, busy = 0, loaded = 0, frame_err = 0.
  - FSM goes to IDLE.
- Input synchronisation:
  - rx passes through a 2-flop synchroniser that resets to 1.
  - load_req is synchronised with 2 flops plus an edge-detect flop.
- Session control:
  - A load_req rising edge sets busy = 1 and cpu_hold = 1, clears loaded and frame_err, sets word counter = 0, and aborts any frame in progress (FSM goes to IDLE).
  - When busy = 0, received frames are fully parsed but never written: mem_we stays 0.
- FSM states and transitions:
  - IDLE: a falling edge on synchronised rx goes to START and clears the baud counter.
  - START: after CLKS_PER_BIT/2 cycles, sample rx. If rx = 1 (false start), go to IDLE. Otherwise go to DATA and clear the bit index.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx = 0: set frame_err, discard the byte, counter unchanged; go to IDLE.
    - rx = 1 and busy = 1: go to WRITE.
    - rx = 1 and busy = 0: go to IDLE.
  - WRITE (exactly 1 cycle): mem_we = 1, mem_addr = counter, mem_opcode = byte[7:4], mem_imm = byte[3:0]. Go to IDLE.
    - The counter increments in the same cycle.
    - If the counter was 15: counter wraps to 0, and on the next cycle busy = 0, cpu_hold = 0, loaded = 1.
- Output timing:
  - mem_addr / mem_opcode / mem_imm are registered and hold their last values between strobes.
  - mem_we is high only in WRITE.
- Latency: mem_we rises 1 cycle after the stop-bit sample point, i.e. about 9.5·CLKS_PER_BIT + 3 cycles after the start edge on the pin.
- Simultaneous events:
  - A load_req edge in the same cycle as WRITE wins: no write occurs, and the counter becomes 0.
  - A frame error does not end the session; the next good byte goes to the same address.
- Reset mid-frame or mid-session: immediate return to the reset state. Memory contents already written are not this block's concern.

Decomposition:
- Shared package td4_pkg holds:
  - the FSM state enum: IDLE, START, DATA, STOP, WRITE;
  - ADDR_W = 4, NIBBLE_W = 4;
  - the byte-to-word split (bits [7:4] opcode, [3:0] immediate).
- One natural sub-module: td4_uart_rx. It contains the synchroniser, baud counter, and START/DATA/STOP parsing, and outputs byte[7:0], byte_valid, and frame_err_pulse.
- td4_prog_loader adds the session, counter, and WRITE logic.

Test Plan (CLKS_PER_BIT = 4):
- Reset then idle: rst_n low 3 cycles, rx = 1 -> all outputs 0; no mem_we for 200 cycles.
- Full load: load_req edge, then send bytes 0x30, 0x31, …, 0x3F -> 16 mem_we pulses, addr 0..15, opcode = 3, imm = 0..F; then loaded = 1, busy = 0, cpu_hold = 0.
- Framing error: in a session, send 0xA5 with stop bit = 0, then 0xB2 -> frame_err = 1; one write of addr 0, opcode B, imm 2.
- False start: in a session, a 1-cycle low glitch on rx -> FSM returns to IDLE; no write; counter stays 0.
- Not busy: after loaded, send 0x7E -> no mem_we; loaded stays 1.
- Restart mid-session: after 5 bytes, load_req edge, then send 0x12 -> write at addr 0 (opcode 1, imm 2); loaded = 0; busy = 1.
